// File: rtl/ha_stimulus_checker_if.sv
// ============================================================================
// Module   : ha_stimulus_checker_if
// Brief    : Operand/result bundle between the stimulus checker and a half adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ha_stimulus_checker_if;
    logic dut_a;
    logic dut_b;
    logic dut_sum;
    logic dut_carry;

    modport master (
        output dut_a,
        output dut_b,
        input  dut_sum,
        input  dut_carry
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        output dut_sum,
        output dut_carry
    );
endinterface

`default_nettype wire

// File: rtl/ha_stimulus_checker.sv
// ============================================================================
// Module   : ha_stimulus_checker
// Brief    : Sweeps all four half-adder input vectors, checks sum/carry and
//            reports a saturating error count plus sticky per-vector flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ha_stimulus_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    ha_stimulus_checker_if.master  ha,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic [3:0]             o_err_count,
    output logic [3:0]             o_fail_vec
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] c_SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] c_LOOPS       = 4'(LOOPS);

    logic [2:0] r_state;
    logic [1:0] r_idx;
    logic [3:0] r_loop;
    logic [3:0] r_set_cnt;
    logic [3:0] r_err;
    logic [3:0] r_fail;
    logic       r_dut_a;
    logic       r_dut_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic [2:0] w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_loop_nxt;
    logic [3:0] w_set_nxt;
    logic [3:0] w_err_nxt;
    logic [3:0] w_fail_nxt;
    logic       w_mismatch;

    // Expected values come from the registered operands, never from the DUT.
    assign w_mismatch = (ha.dut_sum   != (r_dut_a ^ r_dut_b)) ||
                        (ha.dut_carry != (r_dut_a & r_dut_b));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_loop_nxt  = r_loop;
        w_set_nxt   = r_set_cnt;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_DRIVE;
                    w_idx_nxt   = 2'd0;
                    w_loop_nxt  = 4'd0;
                    w_err_nxt   = 4'd0;
                    w_fail_nxt  = 4'd0;
                end
            end
            S_DRIVE: begin
                w_set_nxt   = 4'd0;
                w_state_nxt = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_set_nxt = r_set_cnt + 4'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt         = (r_err == 4'hF) ? r_err : r_err + 4'd1;
                    w_fail_nxt[r_idx] = 1'b1;
                end
                if (r_idx == 2'd3) begin
                    w_idx_nxt   = 2'd0;
                    w_loop_nxt  = r_loop + 4'd1;
                    w_state_nxt = (w_loop_nxt == c_LOOPS) ? S_DONE : S_DRIVE;
                end else begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = S_DRIVE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_loop    <= 4'd0;
            r_set_cnt <= 4'd0;
            r_err     <= 4'd0;
            r_fail    <= 4'd0;
            r_dut_a   <= 1'b0;
            r_dut_b   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_loop    <= w_loop_nxt;
            r_set_cnt <= w_set_nxt;
            r_err     <= w_err_nxt;
            r_fail    <= w_fail_nxt;
            // Operands update on entry to DRIVE so the vector is visible for the whole slot.
            if (w_state_nxt == S_DRIVE) begin
                r_dut_a <= w_idx_nxt[1];
                r_dut_b <= w_idx_nxt[0];
            end
            r_busy <= (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SETTLE) ||
                      (w_state_nxt == S_CHECK);
            r_done <= (w_state_nxt == S_DONE);
            r_pass <= (w_state_nxt == S_DONE) && (w_err_nxt == 4'd0);
        end
    end

    assign ha.dut_a     = r_dut_a;
    assign ha.dut_b     = r_dut_b;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_fail_vec   = r_fail;

endmodule

`default_nettype wire
